biquad_coeff_loader: RTL and testbench

- Host-side writer for the biquad coefficient cascade port: the coefficient data bus, write strobe and update strobe.
- Holds a host-programmable shadow bank of NCOEFF 18-bit coefficients.
- On commit, snapshots the bank and shifts the snapshot into the DSP B-register cascade, highest index first, one per clock. It then issues a single update pulse so every DSP moves B1 into B2 atomically.
- Sits between the register/control interface and one or more biquad filter instances sharing the coefficient bus.

---
 rtl/biquad_pkg.sv | 6 +
 rtl/biquad_coeff_shadow.sv | 46 ++++
 rtl/biquad_coeff_loader.sv | 96 +++++++++
 tb/tb_biquad_coeff_loader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// biquad_pkg: shared coefficient width, loader state encoding and defaults
package biquad_pkg;
  localparam int COEFF_BITS    = 18;
  localparam int DAT_DELAY_DEF = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_UPDATE, ST_DONE} load_state_e;
endpackage

// File: rtl/biquad_coeff_shadow.sv
// biquad_coeff_shadow: host shadow bank with registered readback and write-first snapshot
module biquad_coeff_shadow
  import biquad_pkg::*;
#(
  parameter int NCOEFF  = 2,
  parameter int ADRBITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_i,
  input  logic [ADRBITS-1:0]    adr_i,
  input  logic [COEFF_BITS-1:0] dat_i,
  output logic [COEFF_BITS-1:0] rd_dat_o,
  input  logic                  snap_i,
  input  logic [ADRBITS-1:0]    sel_i,
  output logic [COEFF_BITS-1:0] snap_sel_o,
  output logic [COEFF_BITS-1:0] snap_top_o
);
  logic [COEFF_BITS-1:0] bank_q [NCOEFF];
  logic [COEFF_BITS-1:0] bank_d [NCOEFF];
  logic [COEFF_BITS-1:0] snap_q [NCOEFF];
  logic [COEFF_BITS-1:0] rd_d, rd_q;
  // bank_d is the bank with this cycle's write applied, so a snapshot includes it
  always_comb begin
    rd_d       = '0;
    snap_sel_o = '0;
    for (int i = 0; i < NCOEFF; i++) begin
      bank_d[i] = (wr_i && adr_i == ADRBITS'(i)) ? dat_i : bank_q[i];
      if (adr_i == ADRBITS'(i)) rd_d = bank_q[i];
      if (sel_i == ADRBITS'(i)) snap_sel_o = snap_q[i];
    end
  end
  assign snap_top_o = bank_d[NCOEFF-1];
  assign rd_dat_o   = rd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      bank_q <= '{default: '0};
      snap_q <= '{default: '0};
    end else begin
      rd_q   <= rd_d;
      bank_q <= bank_d;
      if (snap_i) snap_q <= bank_d;
    end
  end
endmodule

// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: shifts a snapshot of the shadow bank into the DSP B cascade, then pulses update
module biquad_coeff_loader
  import biquad_pkg::*;
#(
  parameter int NCOEFF    = 2,
  parameter int ADRBITS   = 4,
  parameter int DAT_DELAY = DAT_DELAY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_i,
  input  logic [ADRBITS-1:0]    cfg_adr_i,
  input  logic [COEFF_BITS-1:0] cfg_dat_i,
  output logic [COEFF_BITS-1:0] cfg_dat_o,
  input  logic                  cfg_commit_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);
  load_state_e           state_q;
  logic [ADRBITS-1:0]    k_q, sel;
  logic                  pend_q, wr_q, upd_q, done_q, start;
  logic [COEFF_BITS-1:0] dat_q, snap_sel, snap_top;

  // a commit arriving in DONE restarts directly, same as a pending one
  assign start = (state_q == ST_IDLE && cfg_commit_i) ||
                 (state_q == ST_DONE && (pend_q || cfg_commit_i));
  // with no data delay the data register must run one index ahead of the strobe
  assign sel = (DAT_DELAY != 0) ? k_q : k_q - 1'b1;

  biquad_coeff_shadow #(.NCOEFF(NCOEFF), .ADRBITS(ADRBITS)) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_i       (cfg_wr_i),
    .adr_i      (cfg_adr_i),
    .dat_i      (cfg_dat_i),
    .rd_dat_o   (cfg_dat_o),
    .snap_i     (start),
    .sel_i      (sel),
    .snap_sel_o (snap_sel),
    .snap_top_o (snap_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= ST_LOAD;
        k_q     <= ADRBITS'(NCOEFF - 1);
        wr_q    <= 1'b1;
        pend_q  <= 1'b0;
        if (DAT_DELAY == 0) dat_q <= snap_top;
      end else begin
        case (state_q)
          ST_LOAD: begin
            pend_q <= pend_q | cfg_commit_i;
            if (DAT_DELAY != 0 || k_q != '0) dat_q <= snap_sel;
            if (k_q == '0) begin
              state_q <= ST_UPDATE;
              wr_q    <= 1'b0;
              upd_q   <= (DAT_DELAY == 0);
            end else begin
              k_q <= k_q - 1'b1;
            end
          end
          ST_UPDATE: begin
            pend_q <= pend_q | cfg_commit_i;
            upd_q  <= !upd_q;
            if (upd_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o         = (state_q != ST_IDLE) || pend_q;
  assign done_o         = done_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: directed checks of the coefficient loader against hand-computed timing
module tb_biquad_coeff_loader;
  logic        clk = 0, rst_n = 0, cfg_wr_i = 0, cfg_commit_i = 0;
  logic [3:0]  cfg_adr_i = 0;
  logic [17:0] cfg_dat_i = 0;
  logic [17:0] cfg_dat_o, coeff_dat_o;
  logic        busy_o, done_o, coeff_wr_o, coeff_update_o;
  int          ncmp = 0, nbad = 0;
  logic        wr_d = 0;
  logic [17:0] b1_lo = 0, b1_hi = 0, b2_lo = 0, b2_hi = 0;

  always #5 clk = ~clk;

  biquad_coeff_loader #(.NCOEFF(2), .ADRBITS(4), .DAT_DELAY(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr_i       (cfg_wr_i),
    .cfg_adr_i      (cfg_adr_i),
    .cfg_dat_i      (cfg_dat_i),
    .cfg_dat_o      (cfg_dat_o),
    .cfg_commit_i   (cfg_commit_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .coeff_dat_o    (coeff_dat_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o)
  );

  // two-DSP receiver: registers the strobe, shifts low into high, update copies B1 to B2
  always @(posedge clk) begin
    wr_d <= coeff_wr_o;
    if (wr_d) begin
      b1_lo <= coeff_dat_o;
      b1_hi <= b1_lo;
    end
    if (coeff_update_o) begin
      b2_lo <= b1_lo;
      b2_hi <= b1_hi;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [3:0] adr, input logic [17:0] dat);
    cfg_wr_i = 1; cfg_adr_i = adr; cfg_dat_i = dat;
    step();
    cfg_wr_i = 0;
  endtask

  task automatic host_rd(input string tag, input logic [3:0] adr, input logic [17:0] expv);
    cfg_adr_i = adr;
    step();
    chk(tag, cfg_dat_o, expv);
  endtask

  task automatic chk_outs(input string tag, input logic wr, input logic upd, input logic dn, input logic bsy);
    chk({tag, "_wr"}, coeff_wr_o, wr);
    chk({tag, "_upd"}, coeff_update_o, upd);
    chk({tag, "_done"}, done_o, dn);
    chk({tag, "_busy"}, busy_o, bsy);
  endtask

  initial begin
    #1;
    chk_outs("in_reset", 0, 0, 0, 0);
    chk("in_reset_dat", coeff_dat_o, 0);
    step(5);
    rst_n = 1;
    step();
    chk_outs("post_reset", 0, 0, 0, 0);
    chk("post_reset_dat", coeff_dat_o, 0);
    for (int a = 0; a < 4; a++) host_rd("rb_reset", 4'(a), 0);

    // basic load
    host_wr(0, 18'h00123);
    host_wr(1, 18'h3FFFF);
    host_rd("rb_adr0", 0, 18'h00123);
    host_rd("rb_adr1", 1, 18'h3FFFF);
    cfg_commit_i = 1;
    step(); cfg_commit_i = 0;
    chk_outs("basic_c1", 1, 0, 0, 1);
    step();
    chk_outs("basic_c2", 1, 0, 0, 1);
    chk("basic_c2_dat", coeff_dat_o, 18'h3FFFF);
    step();
    chk_outs("basic_c3", 0, 0, 0, 1);
    chk("basic_c3_dat", coeff_dat_o, 18'h00123);
    step();
    chk_outs("basic_c4", 0, 1, 0, 1);
    chk("basic_c4_dat_hold", coeff_dat_o, 18'h00123);
    step();
    chk_outs("basic_c5", 0, 0, 1, 1);
    step();
    chk_outs("basic_c6", 0, 0, 0, 0);
    chk("basic_b2_hi", b2_hi, 18'h3FFFF);
    chk("basic_b2_lo", b2_lo, 18'h00123);

    // same-cycle write and commit
    cfg_wr_i = 1; cfg_adr_i = 0; cfg_dat_i = 18'h00055; cfg_commit_i = 1;
    step(); cfg_wr_i = 0; cfg_commit_i = 0;
    chk("byp_c1_wr", coeff_wr_o, 1);
    step();
    chk("byp_c2_dat", coeff_dat_o, 18'h3FFFF);
    step();
    chk("byp_c3_dat", coeff_dat_o, 18'h00055);
    step(3);
    chk_outs("byp_c6", 0, 0, 0, 0);
    chk("byp_b2_lo", b2_lo, 18'h00055);

    // commits during LOAD with a rewrite of adr 1
    cfg_commit_i = 1;
    step();
    cfg_wr_i = 1; cfg_adr_i = 1; cfg_dat_i = 18'h00AAA;
    chk_outs("pend_c1", 1, 0, 0, 1);
    step(); cfg_wr_i = 0;
    chk("pend_c2_dat", coeff_dat_o, 18'h3FFFF);
    step(); cfg_commit_i = 0;
    chk("pend_c3_dat", coeff_dat_o, 18'h00055);
    step();
    chk_outs("pend_c4", 0, 1, 0, 1);
    step();
    chk_outs("pend_c5", 0, 0, 1, 1);
    step();
    chk_outs("pend_c6", 1, 0, 0, 1);
    step();
    chk_outs("pend_c7", 1, 0, 0, 1);
    chk("pend_c7_dat", coeff_dat_o, 18'h00AAA);
    step();
    chk("pend_c8_dat", coeff_dat_o, 18'h00055);
    step();
    chk_outs("pend_c9", 0, 1, 0, 1);
    step();
    chk_outs("pend_c10", 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_outs("pend_tail", 0, 0, 0, 0);
    end
    chk("pend_b2_hi", b2_hi, 18'h00AAA);
    chk("pend_b2_lo", b2_lo, 18'h00055);

    // out-of-range write
    host_wr(7, 18'h12345);
    host_rd("oor_rb7", 7, 0);
    host_rd("oor_rb0", 0, 18'h00055);
    host_rd("oor_rb1", 1, 18'h00AAA);

    // reset abort in cycle 1 of a load
    cfg_commit_i = 1;
    step(); cfg_commit_i = 0;
    chk("abort_c1_wr", coeff_wr_o, 1);
    #3 rst_n = 0;
    #1;
    chk_outs("abort_async", 0, 0, 0, 0);
    chk("abort_async_dat", coeff_dat_o, 0);
    step(2);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_outs("abort_after", 0, 0, 0, 0);
    end
    host_rd("abort_rb1", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
